// File: rtl/scipio_pipe_pkg.sv
// Shared types for the pipeline stall/flush scheduler.
// Contents: FSM state encoding, per-cycle stage control bundle, counter limits.
// Used by: pipe_ctrl and its testbench.
package scipio_pipe_pkg;

  // Encoding is visible on state_o, so values are fixed.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    BR_FLUSH = 2'd2
  } pipe_state_e;

  // One bit per stage-register control; packing order is pc first, MEM/WB last.
  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
    logic memwb_flush;
  } pipe_ctrl_t;

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources of the instruction in ID.
// Ports: ID source addresses + use flags, EX load flag + destination in; load_use out.
// Purely combinational; register 0 never creates a hazard.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd_addr,
  output logic              load_use
);

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit   = id_uses_rs && (id_rs_addr == ex_rd_addr);
    rt_hit   = id_uses_rt && (id_rt_addr == ex_rd_addr);
    load_use = ex_mem_read && (ex_rd_addr != '0) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush scheduler for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// Ports: clk/rst (sync, active-low), hazard + memory handshake inputs; stage stall/flush
// controls (combinational, zero latency), state_o, saturating stall_cnt, sticky timeout_o.
module pipe_ctrl
  import scipio_pipe_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int BR_PENALTY   = 0,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_br_taken,
  input  logic              imem_ready,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_stall,
  output logic              idex_flush,
  output logic              exmem_stall,
  output logic              memwb_flush,
  output logic [1:0]        state_o,
  output logic [15:0]       stall_cnt,
  output logic              timeout_o
);

  localparam int FW = (BR_PENALTY > 0) ? $clog2(BR_PENALTY + 1) : 1;
  localparam int WW = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [FW-1:0] FLUSH_LOAD  = FW'(BR_PENALTY);
  localparam logic [WW-1:0] WAIT_MAX    = WW'(WAIT_TIMEOUT);
  localparam bit            HAS_PENALTY = (BR_PENALTY > 0);

  pipe_state_e   state_q, state_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_q, timeout_d;
  logic [15:0]   stall_cnt_q, stall_cnt_d;
  logic          load_use;
  logic          mem_hold;
  pipe_ctrl_t    ctrl;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .id_rs_addr (id_rs_addr),
    .id_rt_addr (id_rt_addr),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .ex_mem_read(ex_mem_read),
    .ex_rd_addr (ex_rd_addr),
    .load_use   (load_use)
  );

  assign mem_hold = dmem_req && !dmem_ready;

  // Fixed-priority stage controls; reset pushes bubbles everywhere.
  always_comb begin
    ctrl = '0;
    if (!rst) begin
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
      ctrl.memwb_flush = 1'b1;
    end else if (mem_hold) begin
      // EX is frozen too, so a taken branch stays pending until the wait ends.
      ctrl.pc_stall    = 1'b1;
      ctrl.ifid_stall  = 1'b1;
      ctrl.idex_stall  = 1'b1;
      ctrl.exmem_stall = 1'b1;
      ctrl.memwb_flush = 1'b1;
    end else if (ex_br_taken) begin
      ctrl.ifid_flush = 1'b1;
      ctrl.idex_flush = 1'b1;
    end else if (state_q == BR_FLUSH) begin
      ctrl.ifid_flush = 1'b1;
      ctrl.pc_stall   = !imem_ready;
    end else if (load_use && (state_q == RUN)) begin
      ctrl.pc_stall   = 1'b1;
      ctrl.ifid_stall = 1'b1;
      ctrl.idex_flush = 1'b1;
    end else if (!imem_ready) begin
      ctrl.pc_stall   = 1'b1;
      ctrl.ifid_flush = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;

    if (ctrl.pc_stall && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // The wait counter only advances while in MEM_WAIT; reaching the limit
    // flags a timeout but leaves the stall in force.
    if (state_q == MEM_WAIT) begin
      if (wait_cnt_q != WAIT_MAX) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
      if (wait_cnt_d == WAIT_MAX) begin
        timeout_d = 1'b1;
      end
    end

    case (state_q)
      RUN: begin
        if (mem_hold) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end else if (ex_br_taken && HAS_PENALTY) begin
          state_d     = BR_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end
      end
      MEM_WAIT: begin
        if (!mem_hold) begin
          // A non-zero flush count means the wait interrupted a branch flush.
          if (ex_br_taken && HAS_PENALTY) begin
            state_d     = BR_FLUSH;
            flush_cnt_d = FLUSH_LOAD;
          end else if (flush_cnt_q != '0) begin
            state_d = BR_FLUSH;
          end else begin
            state_d = RUN;
          end
        end
      end
      BR_FLUSH: begin
        if (mem_hold) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end else if (ex_br_taken) begin
          flush_cnt_d = FLUSH_LOAD;
        end else if (imem_ready) begin
          // Only a valid fetch counts as a discarded wrong-path instruction.
          flush_cnt_d = flush_cnt_q - 1'b1;
          if (flush_cnt_q == FW'(1)) begin
            state_d = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_stall    = ctrl.pc_stall;
  assign ifid_stall  = ctrl.ifid_stall;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_stall  = ctrl.idex_stall;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_stall = ctrl.exmem_stall;
  assign memwb_flush = ctrl.memwb_flush;
  assign state_o     = state_q;
  assign stall_cnt   = stall_cnt_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl with BR_PENALTY=2, WAIT_TIMEOUT=4.
// Directed scenarios plus random traffic, checked each cycle against a behavioural model.
// Model tracks "waiting", "flush_left" and plain integer counters rather than an FSM.
module tb_pipe_ctrl;

  localparam int AW = 5;
  localparam int BP = 2;
  localparam int WT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs_addr, id_rt_addr, ex_rd_addr;
  logic          id_uses_rs, id_uses_rt, ex_mem_read, ex_br_taken;
  logic          imem_ready, dmem_req, dmem_ready;
  logic          pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush;
  logic [1:0]    state_o;
  logic [15:0]   stall_cnt;
  logic          timeout_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state
  bit waiting;
  int flush_left;
  int wait_cycles;
  bit timeout_m;
  int stalls;

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_AW(AW), .BR_PENALTY(BP), .WAIT_TIMEOUT(WT)) dut (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .ex_br_taken(ex_br_taken), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush),
    .exmem_stall(exmem_stall), .memwb_flush(memwb_flush),
    .state_o(state_o), .stall_cnt(stall_cnt), .timeout_o(timeout_o)
  );

  // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush}
  wire [6:0] ctrl_obs = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [6:0] model_ctrl();
    bit mh, lu;
    mh = dmem_req && !dmem_ready;
    lu = ex_mem_read && (ex_rd_addr != 0) &&
         ((id_uses_rs && id_rs_addr == ex_rd_addr) || (id_uses_rt && id_rt_addr == ex_rd_addr));
    if (!rst)                               return 7'b0010101;
    if (mh)                                 return 7'b1101011;
    if (ex_br_taken)                        return 7'b0010100;
    if (!waiting && flush_left > 0)         return {!imem_ready, 6'b010000};
    if (lu && !waiting && flush_left == 0)  return 7'b1100100;
    if (!imem_ready)                        return 7'b1010000;
    return 7'b0000000;
  endfunction

  function automatic logic [1:0] model_state();
    if (waiting)        return 2'd1;
    if (flush_left > 0) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_step(input bit pc_st);
    bit mh, was_waiting;
    if (!rst) begin
      waiting = 0; flush_left = 0; wait_cycles = 0; timeout_m = 0; stalls = 0;
      return;
    end
    mh = dmem_req && !dmem_ready;
    was_waiting = waiting;
    if (pc_st && stalls < 65535) stalls++;
    if (was_waiting) begin
      if (wait_cycles < WT) wait_cycles++;
      if (wait_cycles >= WT) timeout_m = 1;
    end
    if (was_waiting && !mh) begin
      waiting = 0;
      if (ex_br_taken) flush_left = BP;
    end else if (!was_waiting && mh) begin
      waiting = 1;
      wait_cycles = 0;
    end else if (!was_waiting) begin
      if (ex_br_taken) flush_left = BP;
      else if (flush_left > 0 && imem_ready) flush_left--;
    end
  endtask

  // Inputs must be set before calling; checks at negedge, then advances one clock.
  task automatic tick();
    logic [6:0] exp_ctrl;
    @(negedge clk);
    exp_ctrl = model_ctrl();
    check_eq("ctrl", {25'd0, ctrl_obs}, {25'd0, exp_ctrl});
    check_eq("state", {30'd0, state_o}, {30'd0, model_state()});
    check_eq("stall_cnt", {16'd0, stall_cnt}, stalls);
    check_eq("timeout", {31'd0, timeout_o}, {31'd0, timeout_m});
    model_step(exp_ctrl[6]);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    rst = 1; id_rs_addr = '0; id_rt_addr = '0; ex_rd_addr = '0;
    id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0; ex_br_taken = 0;
    imem_ready = 1; dmem_req = 0; dmem_ready = 0;
  endtask

  initial begin
    idle();
    waiting = 0; flush_left = 0; wait_cycles = 0; timeout_m = 0; stalls = 0;

    // Reset for two cycles: bubbles everywhere, no stalls.
    rst = 0;
    tick(); tick();
    idle();
    check_eq("rst_state", {30'd0, state_o}, 32'd0);
    check_eq("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    tick();

    // Load-use on rt, then same with destination r0.
    ex_mem_read = 1; ex_rd_addr = 5; id_uses_rt = 1; id_rt_addr = 5;
    tick();
    idle();
    check_eq("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    ex_mem_read = 1; ex_rd_addr = 0; id_uses_rt = 1; id_rt_addr = 0;
    tick();
    idle();
    tick();

    // Taken branch then fetch pattern 1,0,1.
    ex_br_taken = 1; tick();
    ex_br_taken = 0;
    imem_ready = 1; tick();
    imem_ready = 0; tick();
    imem_ready = 1; tick();
    check_eq("br_done_state", {30'd0, state_o}, 32'd0);
    tick();

    // Memory wait with a pending branch, then release.
    dmem_req = 1; dmem_ready = 0; ex_br_taken = 1;
    repeat (3) tick();
    dmem_ready = 1;
    tick();
    idle();
    repeat (4) tick();

    // Timeout: six cycles of wait, release, then reset clears it.
    rst = 0; tick(); idle();
    dmem_req = 1; dmem_ready = 0;
    repeat (6) tick();
    dmem_ready = 1; tick();
    idle(); repeat (2) tick();
    check_eq("timeout_sticky", {31'd0, timeout_o}, 32'd1);
    rst = 0; tick(); idle();
    check_eq("timeout_cleared", {31'd0, timeout_o}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(199) != 0);
      id_rs_addr  = AW'($urandom_range(3));
      id_rt_addr  = AW'($urandom_range(3));
      ex_rd_addr  = AW'($urandom_range(3));
      id_uses_rs  = $urandom_range(1);
      id_uses_rt  = $urandom_range(1);
      ex_mem_read = ($urandom_range(2) == 0);
      ex_br_taken = ($urandom_range(7) == 0);
      imem_ready  = ($urandom_range(4) != 0);
      dmem_req    = ($urandom_range(2) == 0);
      dmem_ready  = $urandom_range(1);
      tick();
    end

    // Long fetch wait saturates the stall counter.
    idle();
    imem_ready = 0;
    repeat (70000) tick();
    check_eq("stall_cnt_sat", {16'd0, stall_cnt}, 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
